// File: rtl/block_shifter.sv
// Registered element-granular barrel shifter/rotator: moves ELMS packed elements
// of DATA bits by shamt whole elements, with one output register stage.
module block_shifter #(
  parameter int ROTATE   = 0,
  parameter int TO_RIGHT = 0,
  parameter int ELMS     = 8,
  parameter int DATA     = 8,
  parameter int SHAMT    = $clog2(ELMS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ELMS-1:0][DATA-1:0]  in,
  input  logic [SHAMT-1:0]           shamt,
  output logic                       out_valid,
  output logic [ELMS-1:0][DATA-1:0]  out
);

  localparam bit IS_POW2 = ((ELMS & (ELMS - 1)) == 0);
  localparam logic [SHAMT-1:0] ELMS_S = SHAMT'(ELMS);

  logic [SHAMT-1:0]          w_amt;
  logic                      w_over;
  logic [DATA-1:0]           w_stage [SHAMT+1][ELMS];
  logic [ELMS-1:0][DATA-1:0] w_res;

  // Rotating by a multiple of ELMS is the identity, so reduce first when the
  // element count does not divide the natural shamt range evenly.
  generate
    if (ROTATE != 0 && !IS_POW2) begin : g_mod
      assign w_amt = shamt % ELMS_S;
    end else begin : g_nomod
      assign w_amt = shamt;
    end
  endgenerate

  assign w_over = (ROTATE == 0) && (shamt >= ELMS_S);

  generate
    for (genvar i = 0; i < ELMS; i++) begin : g_io
      assign w_stage[0][i] = in[i];
      assign w_res[i]      = w_over ? '0 : w_stage[SHAMT][i];
    end

    // Stage k moves by 2^k elements when shamt bit k is set.
    for (genvar k = 0; k < SHAMT; k++) begin : g_stage
      for (genvar i = 0; i < ELMS; i++) begin : g_elm
        if (ROTATE != 0) begin : g_rot
          localparam int STEP_MOD = (1 << k) % ELMS;
          localparam int SRC = (TO_RIGHT != 0) ? ((i + STEP_MOD) % ELMS)
                                               : ((i + ELMS - STEP_MOD) % ELMS);
          assign w_stage[k+1][i] = w_amt[k] ? w_stage[k][SRC] : w_stage[k][i];
        end else begin : g_shf
          localparam int SRC = (TO_RIGHT != 0) ? (i + (1 << k)) : (i - (1 << k));
          if (SRC >= 0 && SRC < ELMS) begin : g_in
            assign w_stage[k+1][i] = w_amt[k] ? w_stage[k][SRC] : w_stage[k][i];
          end else begin : g_fill
            assign w_stage[k+1][i] = w_amt[k] ? '0 : w_stage[k][i];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= w_res;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_block_shifter.sv
// Scoreboard bench: eight shifter configurations share one stimulus stream and
// are checked against a per-element index-arithmetic reference model.
module tb_block_shifter;

  logic clk = 1'b0;
  logic reset;
  logic inValid;
  logic [63:0] in8;
  logic [39:0] in5;
  logic [7:0]  in1;
  logic [3:0]  sh8;
  logic [2:0]  sh5;
  logic [0:0]  sh1;

  logic [63:0] outSL8, outSR8, outRL8, outRR8;
  logic [39:0] outRL5, outSR5;
  logic [7:0]  outRL1, outSL1;
  logic [7:0]  gotV;
  logic [7:0][63:0] gotD;

  int cfgRot   [8] = '{0, 0, 1, 1, 1, 0, 1, 0};
  int cfgRight [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
  int cfgElms  [8] = '{8, 8, 8, 8, 5, 5, 1, 1};
  string cfgName [8] = '{"SL8", "SR8", "RL8", "RR8", "RL5", "SR5", "RL1", "SL1"};

  typedef struct {
    logic             v;
    logic [7:0][63:0] e;
  } expEntry_t;

  expEntry_t expQ [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  block_shifter #(.ROTATE(0), .TO_RIGHT(0), .ELMS(8), .DATA(8)) u_sl8 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in8), .shamt(sh8),
    .out_valid(gotV[0]), .out(outSL8));
  block_shifter #(.ROTATE(0), .TO_RIGHT(1), .ELMS(8), .DATA(8)) u_sr8 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in8), .shamt(sh8),
    .out_valid(gotV[1]), .out(outSR8));
  block_shifter #(.ROTATE(1), .TO_RIGHT(0), .ELMS(8), .DATA(8)) u_rl8 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in8), .shamt(sh8),
    .out_valid(gotV[2]), .out(outRL8));
  block_shifter #(.ROTATE(1), .TO_RIGHT(1), .ELMS(8), .DATA(8)) u_rr8 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in8), .shamt(sh8),
    .out_valid(gotV[3]), .out(outRR8));
  block_shifter #(.ROTATE(1), .TO_RIGHT(0), .ELMS(5), .DATA(8)) u_rl5 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in5), .shamt(sh5),
    .out_valid(gotV[4]), .out(outRL5));
  block_shifter #(.ROTATE(0), .TO_RIGHT(1), .ELMS(5), .DATA(8)) u_sr5 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in5), .shamt(sh5),
    .out_valid(gotV[5]), .out(outSR5));
  block_shifter #(.ROTATE(1), .TO_RIGHT(0), .ELMS(1), .DATA(8)) u_rl1 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in1), .shamt(sh1),
    .out_valid(gotV[6]), .out(outRL1));
  block_shifter #(.ROTATE(0), .TO_RIGHT(0), .ELMS(1), .DATA(8)) u_sl1 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(in1), .shamt(sh1),
    .out_valid(gotV[7]), .out(outSL1));

  assign gotD[0] = outSL8;
  assign gotD[1] = outSR8;
  assign gotD[2] = outRL8;
  assign gotD[3] = outRR8;
  assign gotD[4] = {24'h0, outRL5};
  assign gotD[5] = {24'h0, outSR5};
  assign gotD[6] = {56'h0, outRL1};
  assign gotD[7] = {56'h0, outSL1};

  // Result element i comes from source element i-s (left) or i+s (right);
  // rotation wraps the index, shifting drops anything out of range.
  function automatic logic [63:0] refModel(int rot, int right, int elms,
                                           logic [63:0] x, int s);
    logic [63:0] r;
    int j;
    r = '0;
    for (int i = 0; i < elms; i++) begin
      j = (right != 0) ? i + s : i - s;
      if (rot != 0) begin
        j = ((j % elms) + elms) % elms;
        r[i*8 +: 8] = x[j*8 +: 8];
      end else if (j >= 0 && j < elms) begin
        r[i*8 +: 8] = x[j*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] maskElms(int elms, logic [63:0] x);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < elms; i++) m[i*8 +: 8] = 8'hFF;
    return x & m;
  endfunction

  function automatic int shamtFor(int elms, int s);
    if (elms == 8) return s & 15;
    if (elms == 5) return s & 7;
    return s & 1;
  endfunction

  // Drives one cycle of stimulus and queues what every instance should show after the edge.
  task automatic applyStimulus(input logic rst, input logic vld,
                               input logic [63:0] data, input int s);
    expEntry_t ent;
    reset   = rst;
    inValid = vld;
    in8     = data;
    in5     = data[39:0];
    in1     = data[7:0];
    sh8     = 4'(s);
    sh5     = 3'(s);
    sh1     = 1'(s);
    ent.v = rst ? 1'b0 : vld;
    for (int n = 0; n < 8; n++) begin
      if (rst) ent.e[n] = '0;
      else ent.e[n] = refModel(cfgRot[n], cfgRight[n], cfgElms[n],
                               maskElms(cfgElms[n], data), shamtFor(cfgElms[n], s));
    end
    @(posedge clk);
    expQ.push_back(ent);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every queued cycle is compared on the falling edge after its capture edge.
  always @(negedge clk) begin
    expEntry_t ent;
    if (expQ.size() > 0) begin
      ent = expQ.pop_front();
      for (int n = 0; n < 8; n++) begin
        checkOutput({cfgName[n], "_valid"}, {63'h0, gotV[n]}, {63'h0, ent.v});
        checkOutput({cfgName[n], "_data"}, gotD[n], ent.e[n]);
      end
    end
  end

  initial begin
    logic [63:0] ramp;
    ramp = 64'h0807060504030201;
    reset = 1'b1; inValid = 1'b0; in8 = '0; in5 = '0; in1 = '0;
    sh8 = '0; sh5 = '0; sh1 = '0;

    applyStimulus(1'b1, 1'b1, ramp, 3);
    applyStimulus(1'b1, 1'b1, ramp, 5);

    for (int s = 0; s < 16; s++) applyStimulus(1'b0, 1'b1, ramp, s);

    applyStimulus(1'b0, 1'b0, ramp, 1);
    applyStimulus(1'b0, 1'b1, ramp, 2);
    applyStimulus(1'b0, 1'b0, ramp, 3);
    applyStimulus(1'b0, 1'b0, ramp, 4);

    for (int c = 0; c < 150; c++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                    {$urandom(), $urandom()}, int'($urandom_range(0, 15)));

    applyStimulus(1'b1, 1'b1, ramp, 3);
    applyStimulus(1'b0, 1'b0, ramp, 6);
    applyStimulus(1'b0, 1'b1, ramp, 7);

    for (int c = 0; c < 100; c++)
      applyStimulus(1'b0, 1'b1, {$urandom(), $urandom()}, c % 16);

    applyStimulus(1'b0, 1'b0, '0, 0);
    @(negedge clk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d exp=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
